// File: rtl/alu_seq_if.sv
// Requester-side bus of the nibble-serial ALU sequencer.
// Define ALU_SEQ_OVF_EN to add the signed-overflow flag (ovf).
interface alu_seq_if #(
  parameter int NIBBLES = 2
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   op;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         sign;
`ifdef ALU_SEQ_OVF_EN
  logic         ovf;

  modport master (
    output start, op, cin, a, b,
    input  busy, done, result, carry, zero, sign, ovf
  );
  modport slave (
    input  start, op, cin, a, b,
    output busy, done, result, carry, zero, sign, ovf
  );
`else
  modport master (
    output start, op, cin, a, b,
    input  busy, done, result, carry, zero, sign
  );
  modport slave (
    input  start, op, cin, a, b,
    output busy, done, result, carry, zero, sign
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// Runs W-bit operations on a 4-bit ALU one nibble per cycle, LSB first, chaining carry.
// Define ALU_SEQ_OVF_EN to add the signed-overflow flag on the request bus.
module alu_seq #(
  parameter int         NIBBLES  = 2,
  parameter logic [2:0] OP_ADD   = 3'b001,
  parameter logic [2:0] OP_SUB   = 3'b010,
  parameter logic       SUB_CIN0 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   req,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_cin,
  input  logic [3:0] alu_r,
  input  logic       alu_carry
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [2:0]      op_q;
  logic            cin_q;
  logic            chain_q;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, zero_q, sign_q;
  logic            arith, last;
`ifdef ALU_SEQ_OVF_EN
  logic            ovf_q;
`endif

  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last  = (k_q == K_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ALU drive is zero outside RUN so the shared ALU idles deterministically.
  always_comb begin
    state_d  = state_q;
    alu_a    = 4'd0;
    alu_b    = 4'd0;
    alu_op   = 3'd0;
    alu_cin  = 1'b0;
    result_d = result_q;
    unique case (state_q)
      IDLE: if (req.start) state_d = RUN;
      RUN: begin
        alu_op = op_q;
        for (int i = 0; i < NIBBLES; i++) begin
          if (k_q == KW'(i)) begin
            alu_a              = a_q[4*i +: 4];
            alu_b              = b_q[4*i +: 4];
            result_d[4*i +: 4] = alu_r;
          end
        end
        if (k_q == '0)
          alu_cin = (op_q == OP_ADD) ? cin_q : (op_q == OP_SUB) ? SUB_CIN0 : 1'b0;
        else
          alu_cin = arith & chain_q;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flags are computed from the fully assembled result on the last RUN edge,
  // so they are already valid while done is high and hold until the next DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'd0;
      cin_q    <= 1'b0;
      chain_q  <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req.start) begin
            a_q   <= req.a;
            b_q   <= req.b;
            op_q  <= req.op;
            cin_q <= req.cin;
            k_q   <= '0;
          end
        end
        RUN: begin
          result_q <= result_d;
          chain_q  <= alu_carry;
          if (!last) k_q <= k_q + 1'b1;
          if (last) begin
            carry_q <= arith & alu_carry;
            zero_q  <= (result_d == '0);
            sign_q  <= result_d[W-1];
`ifdef ALU_SEQ_OVF_EN
            if (op_q == OP_ADD)
              ovf_q <= (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
            else if (op_q == OP_SUB)
              ovf_q <= (a_q[W-1] != b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
            else
              ovf_q <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign req.busy   = (state_q != IDLE);
  assign req.done   = (state_q == DONE);
  assign req.result = result_q;
  assign req.carry  = carry_q;
  assign req.zero   = zero_q;
  assign req.sign   = sign_q;
`ifdef ALU_SEQ_OVF_EN
  assign req.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: word-level reference model, behavioural 4-bit ALU,
// driver pushes expectations, monitor pops them on every done pulse.
module tb_alu_seq;
  localparam int NIBBLES = 2;
  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         s;
    logic         v;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_a, alu_b, alu_r;
  logic [2:0] alu_op;
  logic       alu_cin, alu_carry;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_seq_if #(.NIBBLES(NIBBLES)) bus();

  alu_seq #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_cin  (alu_cin),
    .alu_r    (alu_r),
    .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU
  always_comb begin
    logic [4:0] s;
    s         = 5'd0;
    alu_r     = 4'd0;
    alu_carry = 1'b0;
    case (alu_op)
      OP_ADD: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        alu_r = s[3:0]; alu_carry = s[4];
      end
      OP_SUB: begin
        s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
        alu_r = s[3:0]; alu_carry = s[4];
      end
      OP_AND:  alu_r = alu_a & alu_b;
      OP_OR:   alu_r = alu_a | alu_b;
      default: ;
    endcase
  end

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t e;
    int   sv;
    e.r = '0; e.c = 1'b0; e.v = 1'b0;
    case (op)
      OP_ADD: begin
        e.r = a + b + W'(cin);
        e.c = (int'(a) + int'(b) + int'(cin)) > (2**W - 1);
        sv  = int'($signed(a)) + int'($signed(b)) + int'(cin);
        e.v = (sv > 2**(W-1) - 1) || (sv < -(2**(W-1)));
      end
      OP_SUB: begin
        e.r = a - b;
        e.c = (a >= b);
        sv  = int'($signed(a)) - int'($signed(b));
        e.v = (sv > 2**(W-1) - 1) || (sv < -(2**(W-1)));
      end
      OP_AND: e.r = a & b;
      OP_OR:  e.r = a | b;
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    e.s = e.r[W-1];
    return e;
  endfunction

  // Carry expected into nibble k, from the word-level sum of the lower bits.
  function automatic logic exp_cin(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin, input int k);
    int m;
    m = (1 << (4*k)) - 1;
    if (op == OP_ADD) return (k == 0) ? cin : (((int'(a) & m) + (int'(b) & m) + int'(cin)) > m);
    if (op == OP_SUB) return (k == 0) ? 1'b1 : ((int'(a) & m) >= (int'(b) & m));
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL done_unexpected: got done=1, want no pending operation");
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'(bus.result), 32'(mon_e.r));
        check("carry",  32'(bus.carry),  32'(mon_e.c));
        check("zero",   32'(bus.zero),   32'(mon_e.z));
        check("sign",   32'(bus.sign),   32'(mon_e.s));
`ifdef ALU_SEQ_OVF_EN
        check("ovf",    32'(bus.ovf),    32'(mon_e.v));
`endif
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin);
    wait_idle();
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
    sb.push_back(model(op, a, b, cin));
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("alu_a_n%0d", k),   32'(alu_a),   32'(a[4*k +: 4]));
      check($sformatf("alu_b_n%0d", k),   32'(alu_b),   32'(b[4*k +: 4]));
      check($sformatf("alu_op_n%0d", k),  32'(alu_op),  32'(op));
      check($sformatf("alu_cin_n%0d", k), 32'(alu_cin), 32'(exp_cin(op, a, b, cin, k)));
      check($sformatf("busy_n%0d", k),    32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    check("done_latency", 32'(bus.done), 32'd1);
    check("alu_op_done",  32'(alu_op),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [2:0] ops [4];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_carry",  32'(bus.carry),  32'd0);
    check("rst_zero",   32'(bus.zero),   32'd0);
    check("rst_sign",   32'(bus.sign),   32'd0);
    check("rst_alu_a",  32'(alu_a),      32'd0);
    check("rst_alu_b",  32'(alu_b),      32'd0);
    check("rst_alu_op", 32'(alu_op),     32'd0);
    check("rst_alu_cin",32'(alu_cin),    32'd0);
`ifdef ALU_SEQ_OVF_EN
    check("rst_ovf",    32'(bus.ovf),    32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    run_op(OP_ADD, 8'h3C, 8'h25, 1'b0);
    run_op(OP_ADD, 8'hFF, 8'h01, 1'b0);
    run_op(OP_SUB, 8'h50, 8'h01, 1'b0);
    run_op(OP_SUB, 8'h80, 8'h01, 1'b0);
    run_op(OP_AND, 8'hF0, 8'h3C, 1'b0);
    run_op(OP_ADD, 8'h7F, 8'h00, 1'b1);

    // start held for six cycles: only two operations may complete
    @(negedge clk);
    wait_idle();
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0;
    sb.push_back(model(OP_ADD, 8'h11, 8'h22, 1'b0));
    sb.push_back(model(OP_ADD, 8'h11, 8'h22, 1'b0));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("held_done_c%0d", c), 32'(bus.done), 32'((c == 3) || (c == 7)));
      if (c == 6) bus.start = 1'b0;
    end

    // reset in the first RUN cycle discards the operation
    wait_idle();
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h55; bus.b = 8'h66; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy",   32'(bus.busy),   32'd0);
    check("mid_rst_done",   32'(bus.done),   32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_alu_op", 32'(alu_op),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(OP_ADD, 8'h12, 8'h34, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(ops[$urandom_range(3)], W'($urandom), W'($urandom), 1'($urandom_range(1)));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
